instr_fetch: RTL

Instruction fetch and program-counter unit for the single-issue MIPS core. It owns the PC, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, and presents it to the instruction decoder. It consumes the decoder's `pc_control` code, together with the register value for JR, to choose the next PC.

---
 rtl/instr_fetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC and fetches one instruction word at a time over a req/ack port.
// Each instruction is fetched (FETCH), presented to the decoder (EXEC), then the next PC is chosen.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pc_control,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] next_pc;
    logic        misaligned;

    function automatic logic [31:0] jump_target(input logic [31:0] link,
                                                input logic [25:0] index);
        return {link[31:28], index, 2'b00};
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] link,
                                                  input logic [15:0] imm);
        logic signed [31:0] offset;
        offset = {{14{imm[15]}}, imm, 2'b00};
        return link + $unsigned(offset);
    endfunction

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // Codes 1xx fall through to the sequential default.
    always_comb begin
        case (pc_control)
            3'b001:  next_pc = jump_target(pc_plus4, instr[25:0]);
            3'b010:  next_pc = jr_target;
            3'b011:  next_pc = branch_target(pc_plus4, instr[15:0]);
            default: next_pc = pc_plus4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (imem_ack) state_nxt = EXEC;
            EXEC:    if (!stall) state_nxt = misaligned ? ERROR : FETCH;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = FETCH;
        endcase
    end

    // Request is gated by rst_n so an in-flight fetch drops the moment reset asserts.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        case (state)
            FETCH:   imem_req = rst_n;
            EXEC:    instr_valid = 1'b1;
            ERROR:   fetch_err = 1'b1;
            default: ;
        endcase
    end

    // On a misaligned target pc is left on the faulting instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            if (state == FETCH && imem_ack) begin
                instr <= imem_rdata;
            end
            if (state == EXEC && !stall && !misaligned) begin
                pc <= next_pc;
            end
        end
    end

endmodule
